uvma_axis_pkt_fifo: RTL

Parametrised AXI-Stream FIFO placed between a stream master and a stream slave. It buffers beats in one of two modes:
- Cut-through: a beat is forwarded as soon as it is stored.
- Store-and-forward: the first beat of a packet is not presented until the whole packet (up to and including tlast) is stored.

It exposes occupancy and packet-count status for the environment and scoreboards. Sideband widths follow the AXIS agent conventions: TDATA_WIDTH is counted in bytes.

---
 rtl/uvma_axis_pkt_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uvma_axis_pkt_fifo.sv
// AXI-Stream beat FIFO with cut-through or store-and-forward presentation,
// plus occupancy / packet-count status and an oversize-packet release pulse.
module uvma_axis_pkt_fifo #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int DEPTH       = 16,
    parameter int PKT_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [8*TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH-1:0]     s_tstrb,
    input  logic [TDATA_WIDTH-1:0]     s_tkeep,
    input  logic                       s_tlast,
    input  logic [TID_WIDTH-1:0]       s_tid,
    input  logic [TDEST_WIDTH-1:0]     s_tdest,
    input  logic [TUSER_WIDTH-1:0]     s_tuser,

    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [8*TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH-1:0]     m_tstrb,
    output logic [TDATA_WIDTH-1:0]     m_tkeep,
    output logic                       m_tlast,
    output logic [TID_WIDTH-1:0]       m_tid,
    output logic [TDEST_WIDTH-1:0]     m_tdest,
    output logic [TUSER_WIDTH-1:0]     m_tuser,

    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 8 * TDATA_WIDTH;
    localparam int BW = DW + 2 * TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [BW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count_next;
    logic [CW-1:0]          pkt_count_next;
    logic                   pkt_release;
    logic                   wr_en;
    logic                   rd_en;

    logic [DW-1:0]          rd_data;
    logic [TDATA_WIDTH-1:0] rd_strb;
    logic [TDATA_WIDTH-1:0] rd_keep;
    logic                   rd_last;
    logic [TID_WIDTH-1:0]   rd_id;
    logic [TDEST_WIDTH-1:0] rd_dest;
    logic [TUSER_WIDTH-1:0] rd_user;

    assign wr_en = s_tvalid && s_tready;
    assign rd_en = m_tvalid && m_tready;

    assign {rd_data, rd_strb, rd_keep, rd_last, rd_id, rd_dest, rd_user} = mem[rd_ptr];

    // In store-and-forward mode a beat is only offered once its packet is
    // complete, unless a full-but-unterminated packet forced a release.
    assign m_tvalid = (count != '0) && ((PKT_MODE == 0) || (pkt_count != '0) || pkt_release);

    assign m_tdata  = m_tvalid ? rd_data : '0;
    assign m_tstrb  = m_tvalid ? rd_strb : '0;
    assign m_tkeep  = m_tvalid ? rd_keep : '0;
    assign m_tlast  = m_tvalid && rd_last;
    assign m_tid    = m_tvalid ? rd_id   : '0;
    assign m_tdest  = m_tvalid ? rd_dest : '0;
    assign m_tuser  = m_tvalid ? rd_user : '0;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_next     = count;
        pkt_count_next = pkt_count;
        if (wr_en && !rd_en)
            count_next = count + CW'(1);
        else if (rd_en && !wr_en)
            count_next = count - CW'(1);
        if ((wr_en && s_tlast) && !(rd_en && rd_last))
            pkt_count_next = pkt_count + CW'(1);
        else if ((rd_en && rd_last) && !(wr_en && s_tlast))
            pkt_count_next = pkt_count - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_count   <= '0;
            s_tready    <= 1'b0;
            pkt_release <= 1'b0;
            oversize    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            pkt_count <= pkt_count_next;
            s_tready  <= (count_next < FULL);
            oversize  <= 1'b0;
            // A full FIFO holding no tlast can never complete its packet.
            if ((PKT_MODE != 0) && (count == FULL) && (pkt_count == '0) && !pkt_release) begin
                pkt_release <= 1'b1;
                oversize    <= 1'b1;
            end else if (rd_en && rd_last) begin
                pkt_release <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    end

endmodule
